// File: rtl/ic_dq_izig.sv
// Dequantizer with inverse zigzag: multiplies zigzag-ordered coefficients by a
// writable quantization table and emits one 8x8 block in raster order.
// Optional build macro DQ_SATURATE_EN clamps products to OUT_W instead of wrapping.
module ic_dq_izig #(
    parameter int COEF_W = 12,
    parameter int Q_W    = 8,
    parameter int OUT_W  = 16
) (
    input  logic                     clock,
    input  logic                     aclr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] in_data,
    input  logic                     qt_wr_en,
    input  logic [5:0]               qt_addr,
    input  logic [Q_W-1:0]           qt_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_last
);

    localparam int PROD_W = COEF_W + Q_W + 1;

    // Zigzag index -> raster index.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_FLUSH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

`ifdef DQ_SATURATE_EN
    localparam logic signed [PROD_W-1:0] P_MAX = {{(PROD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] P_MIN = {{(PROD_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

    function automatic logic signed [OUT_W-1:0] f_fit(input logic signed [PROD_W-1:0] p);
`ifdef DQ_SATURATE_EN
        if (p > P_MAX)
            f_fit = {1'b0, {(OUT_W-1){1'b1}}};
        else if (p < P_MIN)
            f_fit = {1'b1, {(OUT_W-1){1'b0}}};
        else
            f_fit = OUT_W'(p);
`else
        f_fit = OUT_W'(p);
`endif
    endfunction

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [5:0]                r_k;
    logic [5:0]                r_r;
    logic [Q_W-1:0]            r_qt   [64];
    logic signed [OUT_W-1:0]   r_buf  [64];
    logic signed [PROD_W-1:0]  r_prod_p0;
    logic [5:0]                r_addr_p0;
    logic                      r_vld_p0;

    logic                      w_in_xfer;
    logic                      w_out_xfer;
    logic signed [PROD_W-1:0]  w_a;
    logic signed [PROD_W-1:0]  w_b;
    logic signed [PROD_W-1:0]  w_prod;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid && (r_k == 6'd63))
                    w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && (r_r == 6'd63))
                    w_state_nxt = S_FILL;
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // Signed coefficient times unsigned table entry, both widened to the full product width.
    assign w_a    = {{(Q_W+1){in_data[COEF_W-1]}}, in_data};
    assign w_b    = {{(COEF_W+1){1'b0}}, r_qt[r_k]};
    assign w_prod = w_a * w_b;

    assign out_data = out_valid ? r_buf[r_r] : '0;
    assign out_last = out_valid && (r_r == 6'd63);

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_state <= S_FILL;
            r_k     <= '0;
            r_r     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_xfer)
                r_k <= r_k + 6'd1;
            if (w_out_xfer) begin
                if (r_r == 6'd63) begin
                    r_r <= '0;
                    r_k <= '0;
                end else begin
                    r_r <= r_r + 6'd1;
                end
            end
        end
    end

    // Stage p0: registered product and its raster destination.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_vld_p0  <= 1'b0;
            r_prod_p0 <= '0;
            r_addr_p0 <= '0;
        end else begin
            r_vld_p0 <= w_in_xfer;
            if (w_in_xfer) begin
                r_prod_p0 <= w_prod;
                r_addr_p0 <= ZZ[r_k];
            end
        end
    end

    // Stage p1: fitted product lands in the raster-ordered block buffer.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < 64; i++)
                r_buf[i] <= '0;
        end else if (r_vld_p0) begin
            r_buf[r_addr_p0] <= f_fit(r_prod_p0);
        end
    end

    // Table writes land on the edge, so a same-cycle multiply still sees the old entry.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < 64; i++)
                r_qt[i] <= Q_W'(1);
        end else if (qt_wr_en) begin
            r_qt[qt_addr] <= qt_data;
        end
    end

endmodule

// File: tb/tb_ic_dq_izig.sv
// Randomized bench for ic_dq_izig against a block-level dequantize/zigzag model.
module tb_ic_dq_izig;

    localparam int COEF_W = 12;
    localparam int Q_W    = 8;
    localparam int OUT_W  = 16;

    logic                     clock;
    logic                     aclr;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [COEF_W-1:0] in_data;
    logic                     qt_wr_en;
    logic [5:0]               qt_addr;
    logic [Q_W-1:0]           qt_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_last;

    ic_dq_izig #(.COEF_W(COEF_W), .Q_W(Q_W), .OUT_W(OUT_W)) dut (
        .clock(clock), .aclr(aclr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .qt_wr_en(qt_wr_en), .qt_addr(qt_addr), .qt_data(qt_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    int nat    [64];
    int qt_m   [64];
    int exp_r  [64];
    int got_r  [64];
    int stim   [64];
    int k_m;

    task automatic chk(input string tag, input int got, input int expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Zigzag walks the anti-diagonals, alternating direction.
    function automatic void build_nat();
        int i;
        int lo;
        int hi;
        i = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int row = hi; row >= lo; row--) begin
                    nat[i] = row * 8 + (s - row);
                    i++;
                end
            end else begin
                for (int row = lo; row <= hi; row++) begin
                    nat[i] = row * 8 + (s - row);
                    i++;
                end
            end
        end
    endfunction

    function automatic int fit(input longint p);
        longint m;
        longint t;
        m = longint'(1) <<< OUT_W;
`ifdef DQ_SATURATE_EN
        if (p > m / 2 - 1) return int'(m / 2 - 1);
        if (p < -(m / 2)) return int'(-(m / 2));
        return int'(p);
`else
        t = p % m;
        if (t < 0) t = t + m;
        if (t >= m / 2) t = t - m;
        return int'(t);
`endif
    endfunction

    task automatic model_reset();
        k_m = 0;
        for (int i = 0; i < 64; i++) begin
            qt_m[i]  = 1;
            exp_r[i] = 0;
        end
    endtask

    task automatic qt_write(input int a, input int d);
        @(negedge clock);
        qt_wr_en = 1'b1;
        qt_addr  = 6'(a);
        qt_data  = 8'(d);
        @(posedge clock);
        qt_m[a] = d;
        #1 qt_wr_en = 1'b0;
    endtask

    task automatic push(input int v, input bit wr, input int wa, input int wd);
        int t;
        repeat ($urandom_range(0, 2)) @(negedge clock);
        @(negedge clock);
        chk("fill_ov", out_valid, 0);
        chk("fill_od", out_data, 0);
        chk("fill_ol", out_last, 0);
        in_valid = 1'b1;
        in_data  = COEF_W'(v);
        qt_wr_en = wr;
        qt_addr  = 6'(wa);
        qt_data  = 8'(wd);
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clock);
        exp_r[nat[k_m]] = fit(longint'(v) * longint'(qt_m[k_m]));
        if (wr) qt_m[wa] = wd;
        k_m = (k_m + 1) % 64;
        #1;
        in_valid = 1'b0;
        qt_wr_en = 1'b0;
    endtask

    task automatic run_fill(input int wr_k, input int wa, input int wd, input bit rnd_wr);
        bit w;
        int a;
        int d;
        for (int k = 0; k < 64; k++) begin
            w = (k == wr_k);
            a = wa;
            d = wd;
            if (rnd_wr && $urandom_range(0, 7) == 0) begin
                w = 1'b1;
                a = $urandom_range(0, 63);
                d = $urandom_range(0, 255);
            end
            push(stim[k], w, a, d);
        end
        @(negedge clock);
        chk("flush_ov", out_valid, 0);
        chk("flush_ir", in_ready, 0);
        @(negedge clock);
        chk("drain_start_ov", out_valid, 1);
    endtask

    task automatic drain(input int mode);
        int  r;
        int  cyc;
        int  prev;
        bit  rdy;
        bit  stalled;
        r = 0; cyc = 0; prev = 0; stalled = 1'b0;
        while (r < 64 && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            if (!out_valid) begin
                chk("drain_ov", out_valid, 1);
                break;
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 1) : 1'($urandom_range(0, 1));
            out_ready = rdy;
            qt_wr_en  = 1'b0;
            if (mode == 2 && $urandom_range(0, 7) == 0) begin
                qt_wr_en = 1'b1;
                qt_addr  = 6'($urandom_range(0, 63));
                qt_data  = 8'($urandom_range(0, 255));
                qt_m[qt_addr] = int'(qt_data);
            end
            chk("drain_ir", in_ready, 0);
            chk($sformatf("data_r%0d", r), out_data, exp_r[r]);
            chk($sformatf("last_r%0d", r), out_last, (r == 63) ? 1 : 0);
            if (stalled) chk("held", out_data, prev);
            prev    = out_data;
            stalled = !rdy;
            if (rdy) begin
                got_r[r] = out_data;
                r++;
            end
        end
        if (r < 64) chk("drain_count", r, 64);
        @(negedge clock);
        out_ready = 1'b0;
        qt_wr_en  = 1'b0;
        chk("post_ir", in_ready, 1);
        chk("post_ov", out_valid, 0);
        chk("post_od", out_data, 0);
        chk("post_ol", out_last, 0);
        k_m = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        aclr      = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        qt_wr_en  = 1'b0;
        #1;
        chk("rst_ov", out_valid, 0);
        chk("rst_ir", in_ready, 1);
        chk("rst_od", out_data, 0);
        chk("rst_ol", out_last, 0);
        @(negedge clock);
        aclr = 1'b0;
        model_reset();
    endtask

    task automatic rand_stim();
        for (int k = 0; k < 64; k++) stim[k] = int'($urandom_range(0, 4095)) - 2048;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndist;
        bit uniq;
        aclr = 1'b1; in_valid = 1'b0; in_data = '0; qt_wr_en = 1'b0;
        qt_addr = '0; qt_data = '0; out_ready = 1'b0;
        build_nat();
        model_reset();
        repeat (3) @(negedge clock);
        chk("reset_ir", in_ready, 1);
        chk("reset_ov", out_valid, 0);
        chk("reset_od", out_data, 0);
        chk("reset_ol", out_last, 0);
        aclr = 1'b0;

        // Default table, ramp input.
        for (int k = 0; k < 64; k++) stim[k] = k;
        run_fill(-1, 0, 0, 1'b0);
        drain(0);
        chk("ramp_r0", got_r[0], 0);
        chk("ramp_r1", got_r[1], 1);
        chk("ramp_r2", got_r[2], 5);
        chk("ramp_r8", got_r[8], 2);
        chk("ramp_r16", got_r[16], 3);
        chk("ramp_r63", got_r[63], 63);

        // Uniform table of 16, constant -5.
        for (int a = 0; a < 64; a++) qt_write(a, 16);
        for (int k = 0; k < 64; k++) stim[k] = -5;
        run_fill(-1, 0, 0, 1'b0);
        drain(0);
        for (int r = 0; r < 64; r++) chk($sformatf("m80_r%0d", r), got_r[r], -80);

        // Overflow of the DC product.
        qt_write(0, 255);
        rand_stim();
        stim[0] = 2047;
        run_fill(-1, 0, 0, 1'b0);
        drain(0);
`ifdef DQ_SATURATE_EN
        chk("ovf_pos", got_r[0], 32767);
`else
        chk("ovf_pos", got_r[0], -2303);
`endif
        rand_stim();
        stim[0] = -2048;
        run_fill(-1, 0, 0, 1'b0);
        drain(0);
`ifdef DQ_SATURATE_EN
        chk("ovf_neg", got_r[0], -32768);
`else
        chk("ovf_neg", got_r[0], 2048);
`endif

        // Alternating back-pressure with distinct values.
        for (int k = 0; k < 64; k++) stim[k] = k * 7 - 200;
        run_fill(-1, 0, 0, 1'b0);
        drain(1);
        ndist = 0;
        for (int i = 0; i < 64; i++) begin
            uniq = 1'b1;
            for (int j = 0; j < i; j++) if (got_r[j] == got_r[i]) uniq = 1'b0;
            if (uniq) ndist++;
        end
        chk("distinct", ndist, 64);

        // Table write colliding with the transfer that reads it.
        do_reset();
        rand_stim();
        stim[5] = 3;
        run_fill(5, 5, 2, 1'b0);
        drain(0);
        chk("qtw_old", got_r[2], 3);
        rand_stim();
        stim[5] = 3;
        run_fill(-1, 0, 0, 1'b0);
        drain(0);
        chk("qtw_new", got_r[2], 6);

        // Reset in the middle of a fill.
        for (int k = 0; k < 30; k++) push(int'($urandom_range(0, 4095)) - 2048, 1'b0, 0, 0);
        do_reset();
        rand_stim();
        run_fill(-1, 0, 0, 1'b0);
        drain(2);

        // Random blocks with random table traffic and back-pressure.
        for (int b = 0; b < 3; b++) begin
            rand_stim();
            run_fill(-1, 0, 0, 1'b1);
            drain(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ic_dq_izig.md
IC_DQ_IZIG -- requirements
Module: ic_dq_izig

Interface
REQ-001 The block SHALL have the parameter COEF_W, default 12, giving the signed quantized coefficient width.
REQ-002 The block SHALL have the parameter Q_W, default 8, giving the unsigned quantization table entry width.
REQ-003 The block SHALL have the parameter OUT_W, default 16, giving the signed dequantized output width.
REQ-004 The block SHALL have the port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have the port aclr, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have the port in_valid, input, 1 bit: the coefficient input is valid.
REQ-007 The block SHALL have the port in_ready, output, 1 bit: the block accepts a coefficient.
REQ-008 The block SHALL have the port in_data, input, COEF_W bits: signed quantized coefficient, zigzag order.
REQ-009 The block SHALL have the port qt_wr_en, input, 1 bit: quantization table write strobe.
REQ-010 The block SHALL have the port qt_addr, input, 6 bits: table address, zigzag index.
REQ-011 The block SHALL have the port qt_data, input, Q_W bits: table entry.
REQ-012 The block SHALL have the port out_valid, output, 1 bit: dequantized output is valid.
REQ-013 The block SHALL have the port out_ready, input, 1 bit: the downstream block accepts the output.
REQ-014 The block SHALL have the port out_data, output, OUT_W bits: signed dequantized coefficient, raster order.
REQ-015 The block SHALL have the port out_last, output, 1 bit: marks raster index 63.

Function
REQ-016 An input transfer SHALL occur on a clock edge where in_valid and in_ready are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-017 The FSM SHALL have three states: FILL (in_ready=1), FLUSH (in_ready=0, one cycle) and DRAIN (in_ready=0).
REQ-018 In FILL, a 6-bit zigzag counter k SHALL increment on each input transfer.
- Product in_data*qt[k] is signed x unsigned, COEF_W+Q_W+1 bits, registered one cycle (pipeline=1).
- The registered product SHALL be written to buffer[nat(k)] on the following edge.
- nat() is the standard JPEG zigzag map, e.g. 0->0, 1->1, 2->8, 3->16, 4->9, 5->2, 63->63.
REQ-019 The input transfer with k=63 SHALL move the FSM to FLUSH; FLUSH SHALL move unconditionally to DRAIN on the next edge.
- out_valid SHALL first be 1 two cycles after the k=63 transfer.
REQ-020 In DRAIN, the block SHALL present buffer[r] with out_valid=1, r=0..63.
- r increments only on an output transfer; out_data is held stable while out_ready=0.
- out_last=1 exactly when r=63.
REQ-021 The output transfer with r=63 SHALL move the FSM to FILL (in_ready=1 the next cycle) and clear k and r.
REQ-022 When out_valid=0, out_data and out_last SHALL be 0.
REQ-023 A table write SHALL set qt[qt_addr]=qt_data on the edge; a same-cycle input transfer using that entry SHALL use the old value.
- Table writes are accepted in any state.
REQ-024 The block SHALL never drop or duplicate a coefficient under any in_valid/out_ready pattern.

Reset
REQ-025 While aclr=1, the block SHALL immediately force:
- state=FILL, k=0, r=0;
- in_ready=1 once aclr is released;
- out_valid=0, out_data=0, out_last=0;
- product register=0, all buffer entries=0, all qt entries=1.
REQ-026 Reset asserted mid-block SHALL discard the partial block, and the next transfer after release SHALL be taken as zigzag index 0.

Configuration
REQ-027 With DQ_SATURATE_EN defined, the product SHALL be clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1] before buffering.
REQ-028 Without DQ_SATURATE_EN defined, the low OUT_W bits of the product SHALL be buffered (wrap).

Verification
REQ-029 The bench SHALL cover default table, in_data=k for k=0..63, out_ready=1 -> raster outputs r0=0, r1=1, r2=5, r8=2, r16=3, r63=63; out_last only on r63.
REQ-030 The bench SHALL cover all qt entries=16 and every in_data=-5 -> all 64 outputs = -80.
REQ-031 The bench SHALL cover qt[0]=255 with in_data 2047 at k=0, then -2048 at k=0 -> r0 = 32767 and -32768 with DQ_SATURATE_EN; r0 = -2303 and 2048 without.
REQ-032 The bench SHALL cover out_ready toggling 1-0-1 each cycle in DRAIN -> 64 distinct in-order values, out_data held while stalled, in_ready=0 until the cycle after the r=63 transfer.
REQ-033 The bench SHALL cover aclr pulsed after 30 input transfers -> out_valid=0, in_ready=1; the next 64 transfers form a complete, correct block.
REQ-034 The bench SHALL cover a qt write of 2 to address 5 in the same cycle as the k=5 input transfer of value 3 -> r2=3 (old entry 1); the next block gives r2=6.
